// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32I pipeline register bank.
// Stage payload structs exclude the opaque control bundle, whose width is a top-level parameter.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        valid;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm_ext;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        valid;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } mem_wb_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: clr loads the bubble value and wins over en; en low holds.
module pipe_stage_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d_in,
  input  logic [W-1:0] bubble,
  output logic [W-1:0] q_out
);

  logic [W-1:0] data_d;
  logic [W-1:0] data_q;

  // next-state select: bubble, capture or hold
  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = bubble;
    end else if (en) begin
      data_d = d_in;
    end else begin
      data_d = data_q;
    end
  end

  // stage storage with synchronous reset to the bubble value
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= bubble;
    end else begin
      data_q <= data_d;
    end
  end

  assign q_out = data_q;

endmodule

// File: rtl/pipeline_regs.sv
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers of the 5-stage RV32I core,
// driven by the hazard unit's stall/flush controls, plus retire/bubble counters.
module pipeline_regs
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CTRL_W   = 8,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic              flushE,
  input  logic [31:0]       pcNextF,
  output logic [31:0]       pcF,
  input  logic [31:0]       instrF,
  input  logic [31:0]       pcPlus4F,
  output logic [31:0]       instrD,
  output logic [31:0]       pcD,
  output logic [31:0]       pcPlus4D,
  output logic              validD,
  output logic [4:0]        rs1D,
  output logic [4:0]        rs2D,
  input  logic              regWriteD,
  input  logic [CTRL_W-1:0] ctrlD,
  input  logic [31:0]       rd1D,
  input  logic [31:0]       rd2D,
  input  logic [31:0]       immExtD,
  input  logic [4:0]        rdD,
  output logic              regWriteE,
  output logic              validE,
  output logic [CTRL_W-1:0] ctrlE,
  output logic [31:0]       rd1E,
  output logic [31:0]       rd2E,
  output logic [31:0]       immExtE,
  output logic [31:0]       pcE,
  output logic [31:0]       pcPlus4E,
  output logic [4:0]        rs1E,
  output logic [4:0]        rs2E,
  output logic [4:0]        rdE,
  input  logic [31:0]       aluResultE,
  input  logic [31:0]       writeDataE,
  output logic              regWriteM,
  output logic              validM,
  output logic [CTRL_W-1:0] ctrlM,
  output logic [31:0]       aluResultM,
  output logic [31:0]       writeDataM,
  output logic [31:0]       pcPlus4M,
  output logic [4:0]        rdM,
  input  logic [31:0]       readDataM,
  output logic              regWriteW,
  output logic              validW,
  output logic [CTRL_W-1:0] ctrlW,
  output logic [31:0]       aluResultW,
  output logic [31:0]       readDataW,
  output logic [31:0]       pcPlus4W,
  output logic [4:0]        rdW,
  output logic [CNT_W-1:0]  retiredCount,
  output logic [CNT_W-1:0]  bubbleCount
);

  localparam int IF_ID_W  = $bits(if_id_t);
  localparam int ID_EX_W  = $bits(id_ex_t) + CTRL_W;
  localparam int EX_MEM_W = $bits(ex_mem_t) + CTRL_W;
  localparam int MEM_WB_W = $bits(mem_wb_t) + CTRL_W;

  logic [31:0]      pc_d, pc_q;
  logic [CNT_W-1:0] retired_d, retired_q;
  logic [CNT_W-1:0] bubble_d, bubble_q;

  if_id_t  if_id_d, if_id_q;
  id_ex_t  id_ex_d, id_ex_q;
  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;
  logic [CTRL_W-1:0] ctrl_e_q, ctrl_m_q, ctrl_w_q;

  // PC next-state and perf counter increments
  always_comb begin
    pc_d      = pc_q;
    retired_d = retired_q;
    bubble_d  = bubble_q;
    if (stallF) begin
      pc_d = pc_q;
    end else begin
      pc_d = pcNextF;
    end
    if (mem_wb_q.valid) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // PC and counter storage
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      retired_q <= '0;
      bubble_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      bubble_q  <= bubble_d;
    end
  end

  // stage payloads; a bubble in D never requests a write in E
  always_comb begin
    if_id_d = '{instr: instrF, pc: pc_q, pc_plus4: pcPlus4F, valid: 1'b1};

    id_ex_d = '{reg_write: regWriteD & if_id_q.valid, valid: if_id_q.valid,
                rd1: rd1D, rd2: rd2D, imm_ext: immExtD,
                pc: if_id_q.pc, pc_plus4: if_id_q.pc_plus4,
                rs1: if_id_q.instr[19:15], rs2: if_id_q.instr[24:20], rd: rdD};

    ex_mem_d = '{reg_write: id_ex_q.reg_write, valid: id_ex_q.valid,
                 alu_result: aluResultE, write_data: writeDataE,
                 pc_plus4: id_ex_q.pc_plus4, rd: id_ex_q.rd};

    mem_wb_d = '{reg_write: ex_mem_q.reg_write, valid: ex_mem_q.valid,
                 alu_result: ex_mem_q.alu_result, read_data: readDataM,
                 pc_plus4: ex_mem_q.pc_plus4, rd: ex_mem_q.rd};
  end

  pipe_stage_reg #(.W(IF_ID_W)) u_if_id (
    .clk(clk), .rst(rst), .en(~stallD), .clr(flushD),
    .d_in(if_id_d), .bubble(IF_ID_BUBBLE), .q_out(if_id_q)
  );

  pipe_stage_reg #(.W(ID_EX_W)) u_id_ex (
    .clk(clk), .rst(rst), .en(1'b1), .clr(flushE),
    .d_in({ctrlD, id_ex_d}), .bubble({ID_EX_W{1'b0}}), .q_out({ctrl_e_q, id_ex_q})
  );

  pipe_stage_reg #(.W(EX_MEM_W)) u_ex_mem (
    .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0),
    .d_in({ctrl_e_q, ex_mem_d}), .bubble({EX_MEM_W{1'b0}}), .q_out({ctrl_m_q, ex_mem_q})
  );

  pipe_stage_reg #(.W(MEM_WB_W)) u_mem_wb (
    .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0),
    .d_in({ctrl_m_q, mem_wb_d}), .bubble({MEM_WB_W{1'b0}}), .q_out({ctrl_w_q, mem_wb_q})
  );

  assign pcF          = pc_q;
  assign instrD       = if_id_q.instr;
  assign pcD          = if_id_q.pc;
  assign pcPlus4D     = if_id_q.pc_plus4;
  assign validD       = if_id_q.valid;
  assign rs1D         = if_id_q.instr[19:15];
  assign rs2D         = if_id_q.instr[24:20];

  assign regWriteE    = id_ex_q.reg_write;
  assign validE       = id_ex_q.valid;
  assign ctrlE        = ctrl_e_q;
  assign rd1E         = id_ex_q.rd1;
  assign rd2E         = id_ex_q.rd2;
  assign immExtE      = id_ex_q.imm_ext;
  assign pcE          = id_ex_q.pc;
  assign pcPlus4E     = id_ex_q.pc_plus4;
  assign rs1E         = id_ex_q.rs1;
  assign rs2E         = id_ex_q.rs2;
  assign rdE          = id_ex_q.rd;

  assign regWriteM    = ex_mem_q.reg_write;
  assign validM       = ex_mem_q.valid;
  assign ctrlM        = ctrl_m_q;
  assign aluResultM   = ex_mem_q.alu_result;
  assign writeDataM   = ex_mem_q.write_data;
  assign pcPlus4M     = ex_mem_q.pc_plus4;
  assign rdM          = ex_mem_q.rd;

  assign regWriteW    = mem_wb_q.reg_write;
  assign validW       = mem_wb_q.valid;
  assign ctrlW        = ctrl_w_q;
  assign aluResultW   = mem_wb_q.alu_result;
  assign readDataW    = mem_wb_q.read_data;
  assign pcPlus4W     = mem_wb_q.pc_plus4;
  assign rdW          = mem_wb_q.rd;

  assign retiredCount = retired_q;
  assign bubbleCount  = bubble_q;

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed bench for pipeline_regs: reset, straight flow, load-use stall, branch flush,
// stall/flush priority, counter wrap (CNT_W=4) and mid-stream reset.
module tb_pipeline_regs;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stallF = 1'b0, stallD = 1'b0, flushD = 1'b0, flushE = 1'b0;
  logic [31:0] pcNextF, pcF, instrF, pcPlus4F;
  logic [31:0] instrD, pcD, pcPlus4D;
  logic        validD;
  logic [4:0]  rs1D, rs2D;
  logic        regWriteD;
  logic [7:0]  ctrlD;
  logic [31:0] rd1D, rd2D, immExtD;
  logic [4:0]  rdD;
  logic        regWriteE, validE;
  logic [7:0]  ctrlE;
  logic [31:0] rd1E, rd2E, immExtE, pcE, pcPlus4E;
  logic [4:0]  rs1E, rs2E, rdE;
  logic [31:0] aluResultE, writeDataE;
  logic        regWriteM, validM;
  logic [7:0]  ctrlM;
  logic [31:0] aluResultM, writeDataM, pcPlus4M;
  logic [4:0]  rdM;
  logic [31:0] readDataM;
  logic        regWriteW, validW;
  logic [7:0]  ctrlW;
  logic [31:0] aluResultW, readDataW, pcPlus4W;
  logic [4:0]  rdW;
  logic [3:0]  retiredCount, bubbleCount;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0]  idx;
  logic [11:0] imm;
  logic [4:0]  rdv;

  always #5 clk = ~clk;

  // fetch model: word i at RST_PC+4i is "addi x(i+1), x0, i+1"
  always_comb begin
    idx      = 5'((pcF - RST_PC) >> 2);
    imm      = {7'd0, idx} + 12'd1;
    rdv      = idx + 5'd1;
    instrF   = {imm, 5'd0, 3'd0, rdv, 7'h13};
    pcPlus4F = pcF + 32'd4;
  end

  assign pcNextF    = pcF + 32'd4;
  assign regWriteD  = 1'b1;
  assign ctrlD      = instrD[14:7];
  assign rd1D       = 32'd0;
  assign rd2D       = 32'h0000_0055;
  assign immExtD    = {{20{instrD[31]}}, instrD[31:20]};
  assign rdD        = instrD[11:7];
  assign aluResultE = rd1E + immExtE;
  assign writeDataE = rd2E;
  assign readDataM  = aluResultM ^ 32'hFFFF_0000;

  pipeline_regs #(.RESET_PC(RST_PC), .CTRL_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
    .pcNextF(pcNextF), .pcF(pcF), .instrF(instrF), .pcPlus4F(pcPlus4F),
    .instrD(instrD), .pcD(pcD), .pcPlus4D(pcPlus4D), .validD(validD), .rs1D(rs1D), .rs2D(rs2D),
    .regWriteD(regWriteD), .ctrlD(ctrlD), .rd1D(rd1D), .rd2D(rd2D), .immExtD(immExtD), .rdD(rdD),
    .regWriteE(regWriteE), .validE(validE), .ctrlE(ctrlE), .rd1E(rd1E), .rd2E(rd2E),
    .immExtE(immExtE), .pcE(pcE), .pcPlus4E(pcPlus4E), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .aluResultE(aluResultE), .writeDataE(writeDataE),
    .regWriteM(regWriteM), .validM(validM), .ctrlM(ctrlM), .aluResultM(aluResultM),
    .writeDataM(writeDataM), .pcPlus4M(pcPlus4M), .rdM(rdM), .readDataM(readDataM),
    .regWriteW(regWriteW), .validW(validW), .ctrlW(ctrlW), .aluResultW(aluResultW),
    .readDataW(readDataW), .pcPlus4W(pcPlus4W), .rdW(rdW),
    .retiredCount(retiredCount), .bubbleCount(bubbleCount)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    check_eq("rst_pcF", pcF, RST_PC);
    check_eq("rst_instrD", instrD, 32'h0000_0013);
    check_eq("rst_valid", 32'({validD, validE, validM, validW}), 32'h0);
    check_eq("rst_regwrite", 32'({regWriteE, regWriteM, regWriteW}), 32'h0);
    check_eq("rst_retired", 32'(retiredCount), 32'h0);
    check_eq("rst_bubble", 32'(bubbleCount), 32'h0);
    check_eq("rst_rdW", 32'(rdW), 32'h0);

    // straight-line flow
    tick();
    check_eq("flow_validD", 32'(validD), 32'h1);
    check_eq("flow_pcD", pcD, 32'h0000_0100);
    check_eq("flow_rs2D", 32'(rs2D), 32'h1);
    tick();
    tick();
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_eq($sformatf("flow_rdW_%0d", k), 32'(rdW), 32'(k));
      check_eq($sformatf("flow_aluW_%0d", k), aluResultW, 32'(k));
      check_eq($sformatf("flow_rdataW_%0d", k), readDataW, 32'(k) ^ 32'hFFFF_0000);
      check_eq($sformatf("flow_pc4W_%0d", k), pcPlus4W, 32'h0000_0100 + 32'(4 * k));
      check_eq($sformatf("flow_ctrlW_%0d", k), 32'(ctrlW), 32'(k));
      check_eq($sformatf("flow_vwW_%0d", k), 32'({validW, regWriteW}), 32'h3);
    end
    tick();
    check_eq("flow_retired", 32'(retiredCount), 32'd5);
    check_eq("flow_bubble", 32'(bubbleCount), 32'd4);

    // load-use stall
    do_reset();
    tick(); tick(); tick();
    stallF = 1'b1; stallD = 1'b1; flushE = 1'b1;
    tick();
    stallF = 1'b0; stallD = 1'b0; flushE = 1'b0;
    check_eq("stall_pcF", pcF, 32'h0000_010C);
    check_eq("stall_instrD", instrD, 32'h0030_0193);
    check_eq("stall_E", 32'({validE, regWriteE, rdE}), 32'h0);
    tick();
    check_eq("stall_resume_rdE", 32'(rdE), 32'd3);
    tick();
    check_eq("stall_validW", 32'(validW), 32'h0);
    check_eq("stall_bubble_pre", 32'(bubbleCount), 32'd4);
    tick();
    check_eq("stall_bubble_post", 32'(bubbleCount), 32'd5);
    check_eq("stall_retired", 32'(retiredCount), 32'd2);

    // branch flush
    do_reset();
    tick(); tick(); tick();
    flushD = 1'b1; flushE = 1'b1;
    tick();
    flushD = 1'b0; flushE = 1'b0;
    check_eq("flush_validDE", 32'({validD, validE}), 32'h0);
    check_eq("flush_instrD", instrD, 32'h0000_0013);
    tick();
    check_eq("flush_w1", 32'({validW, rdW}), 32'h22);
    tick();
    check_eq("flush_bub1", 32'(validW), 32'h0);
    tick();
    check_eq("flush_bub2", 32'(validW), 32'h0);
    tick();
    check_eq("flush_w4", 32'({validW, rdW}), 32'h25);
    tick();
    check_eq("flush_bubble", 32'(bubbleCount), 32'd6);
    check_eq("flush_retired", 32'(retiredCount), 32'd3);

    // stallD with flushD: flush wins
    do_reset();
    tick(); tick();
    stallD = 1'b1; flushD = 1'b1;
    tick();
    stallD = 1'b0; flushD = 1'b0;
    check_eq("sf_instrD", instrD, 32'h0000_0013);
    check_eq("sf_validD", 32'(validD), 32'h0);
    check_eq("sf_pcD", pcD, 32'h0);

    // counter wrap then mid-stream reset
    do_reset();
    repeat (21) tick();
    check_eq("wrap_retired", 32'(retiredCount), 32'd1);
    check_eq("wrap_bubble", 32'(bubbleCount), 32'd4);
    check_eq("wrap_validW", 32'(validW), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_valid", 32'({validD, validE, validM, validW}), 32'h0);
    check_eq("midrst_pcF", pcF, RST_PC);
    check_eq("midrst_cnt", 32'({retiredCount, bubbleCount}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_regs.md
# pipeline_regs

Pipeline register bank for the 5-stage RV32I core: PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It is the receiving end of the hazard unit's control interface. It obeys `stallF`/`stallD`/`flushD`/`flushE` and returns the register-index and write-enable fields the hazard unit consumes. It also maintains valid bits per stage and two performance counters (retired instructions, bubbles at writeback).

## Interface
Parameters
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `CTRL_W`, 8, width of opaque decode-control bundle carried D→W (excludes regWrite)
- `CNT_W`, 32, performance counter width

Ports
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stallF, stallD, flushD, flushE`  in  1 each  from hazard unit
- `pcNextF`  in  32  next PC selected by fetch mux
- `pcF`  out  32  current fetch PC
- `instrF, pcPlus4F`  in  32 each  fetch results
- `instrD, pcD, pcPlus4D`  out  32 each  IF/ID contents
- `validD`  out  1  IF/ID holds a real instruction
- `rs1D, rs2D`  out  5 each  `instrD[19:15]`, `instrD[24:20]` (combinational from register)
- `regWriteD`  in  1; `ctrlD`  in  CTRL_W; `rd1D, rd2D, immExtD`  in  32 each; `rdD`  in  5
- `regWriteE, validE`  out  1; `ctrlE`  out  CTRL_W; `rd1E, rd2E, immExtE, pcE, pcPlus4E`  out  32; `rs1E, rs2E, rdE`  out  5
- `aluResultE, writeDataE`  in  32 each
- `regWriteM, validM`  out  1; `ctrlM`  out  CTRL_W; `aluResultM, writeDataM, pcPlus4M`  out  32; `rdM`  out  5
- `readDataM`  in  32
- `regWriteW, validW`  out  1; `ctrlW`  out  CTRL_W; `aluResultW, readDataW, pcPlus4W`  out  32; `rdW`  out  5
- `retiredCount, bubbleCount`  out  CNT_W  performance counters

## Operation
- PC: `rst` → `RESET_PC`; else `stallF` → hold; else load `pcNextF`.
- IF/ID: `rst` or `flushD` → `instrD`=32'h0000_0013 (NOP), `pcD`/`pcPlus4D`=0, `validD`=0; else `stallD` → hold; else capture F inputs and set `validD`=1.
- `flushD` has priority over `stallD`. A branch redirect coinciding with a load-use stall discards the wrong-path instruction.
- ID/EX: `rst` or `flushE` → bubble: `regWriteE`=0, `validE`=0, `ctrlE`=0, `rs1E`/`rs2E`/`rdE`=0, data fields 0. Otherwise capture D-stage inputs, `rs1D`/`rs2D`, `pcD`/`pcPlus4D`, and `validE`=`validD`. No stall input exists for this stage.
- `regWriteE` is forced to 0 whenever `validD`=0 at capture, so bubbles never request a write.
- EX/MEM, MEM/WB: always advance. `rst` clears all fields including `validM`, `validW`, `regWriteM`, `regWriteW` and `rd*`.
- Counters: `rst` → 0. Each cycle after reset, `validW`=1 increments `retiredCount`; otherwise `bubbleCount` increments. Both wrap modulo 2^CNT_W silently.
- Reset mid-operation: every stage bubbles on the same edge; the PC restarts at `RESET_PC`.

## Timing
- All outputs are registered except `rs1D`/`rs2D`, which are a pure bit-slice of `instrD`.
- Reset values: `pcF`=`RESET_PC`; `instrD`=NOP. Every other output is 0, including all valid bits, regWrite bits and counters.
- Flow latency F→W is 4 edges: an instruction fetched at edge n is in W after edge n+4.
- Stall: with `stallF`=`stallD`=1 and `flushE`=1 for one cycle, PC and IF/ID hold and one bubble enters E. The pipeline resumes on the next edge.
- Flush: `flushD`+`flushE` on one edge inserts two bubbles, visible at W two and three edges later.
- Counter updates are visible one cycle after the corresponding `validW` value.

## Structure
- Shared package `pipe_pkg`: `NOP_INSTR` constant (32'h0000_0013), `RESET_PC` default, and packed structs `if_id_t`, `id_ex_t`, `ex_mem_t`, `mem_wb_t`.
- Natural sub-module: `pipe_stage_reg`, a generic packed-struct register with `en` (hold when low), `clr` (load bubble value), and `clr` over `en` priority. It is instantiated four times. The PC and counters are inline.

## Test plan
- Reset: drive `rst`=1 for 2 cycles → `pcF`=RESET_PC, `instrD`=32'h0000_0013, all valid/regWrite=0, both counters=0.
- Straight-line flow: 5 instructions with rd=1..5, no hazards → each appears at W 4 edges after fetch; `retiredCount`=5 after the last reaches W.
- Load-use stall: one cycle of `stallF`=`stallD`=`flushE`=1 → `pcF` and `instrD` unchanged across the edge, `validE`=0, `rdE`=0, `regWriteE`=0; `bubbleCount` +1 three edges later.
- Branch flush: `flushD`=`flushE`=1 for one cycle → `validD`=`validE`=0 next cycle; exactly 2 bubbles reach W.
- Simultaneous `stallD`=1 and `flushD`=1 → IF/ID cleared to NOP (flush wins), `validD`=0.
- Counter wrap with CNT_W=4: run 17 valid instructions → `retiredCount` reads 1. Assert `rst` mid-stream → every valid bit is 0 on the next cycle.
